controller: RTL
===============

Name: controller

Overview:
Sequencer for the 10-bit shared-bus datapath: register file, A/G ALU registers, external input switch.
- Latches a 10-bit instruction when EXEC is asserted.
- Steps an internal 2-bit timestep counter through T0..T3.
- Drives the bus-driver selects, register-file addresses and write strobes, ALU opcode, and the TIME/DONE indications consumed by the display block.

Parameters:
DATA_W, 10, instruction/bus width; only 10 supported.
ADDR_W, 2, register-file address width; 4 registers R0..R3.

Ports:
CLK  in  1  system clock, rising edge.
RESETb  in  1  asynchronous active-low reset.
INSTR  in  DATA_W  instruction from input switches; sampled only at T0.
EXEC  in  1  start request, active-high, level-sensitive.
TIME  out  2  current timestep; feeds display THEX.
DONE  out  1  high during the last timestep of an instruction; feeds display (decimal point).
EXT_OE  out  1  external input drives BUS.
REG_OE  out  1  register file Q1 drives BUS.
G_OE  out  1  G register drives BUS.
RD_ADDR  out  ADDR_W  register file Q1 read address.
WR_EN  out  1  register file write strobe; takes BUS at the CLK edge.
WR_ADDR  out  ADDR_W  register file write address.
A_EN  out  1  load A from BUS.
G_EN  out  1  load G from ALU result.
ALU_OP  out  2  00 ADD, 01 SUB, 10 INV (~BUS), 11 PASS.

Behaviour:
- Instruction format: INSTR[9:6] OP, [5:4] RX, [3:2] RY, [1:0] ignored. IR holds a 10-bit copy.
- Reset (RESETb=0, asynchronous, also mid-instruction):
  - TIME=0, IR=0.
  - All enables/OE/WR_EN/DONE=0.
  - RD_ADDR=WR_ADDR=0, ALU_OP=PASS.
  - Counter resumes from T0 after release.
- All outputs are decoded combinationally from (TIME, IR) only. There are no glitch paths from INSTR or EXEC.
- T0 (idle):
  - All outputs inactive.
  - EXEC=1 at a CLK edge: IR<=INSTR, TIME<=1.
  - EXEC=0: TIME stays 0.
  - T0 always lasts at least 1 cycle.
- Timestep actions, with RX/RY taken from IR:
  - LOAD (0000), T1: EXT_OE, WR_EN, WR_ADDR=RX, DONE.
  - COPY (0001), T1: REG_OE, RD_ADDR=RY, WR_EN, WR_ADDR=RX, DONE.
  - ADD (0010) / SUB (0011):
    - T1: REG_OE, RD_ADDR=RX, A_EN.
    - T2: REG_OE, RD_ADDR=RY, G_EN, ALU_OP=ADD/SUB.
    - T3: G_OE, WR_EN, WR_ADDR=RX, DONE.
  - INV (0100):
    - T1: REG_OE, RD_ADDR=RY, G_EN, ALU_OP=INV.
    - T2: G_OE, WR_EN, WR_ADDR=RX, DONE.
  - Any other OP: T1 with DONE only (NOP).
- Counter: at a CLK edge with DONE=1, TIME<=0. Otherwise, when TIME≠0, TIME<=TIME+1. DONE never coincides with T0.
- Latency from the EXEC-sampling edge to the DONE cycle:
  - LOAD/COPY/NOP: DONE in cycle 1.
  - INV: DONE in cycle 2.
  - ADD/SUB: DONE in cycle 3.
- Bus exclusivity: at most one of EXT_OE/REG_OE/G_OE is high in any cycle. This is required as an assertion.
- EXEC is ignored while TIME≠0. INSTR changes mid-instruction have no effect.
- EXEC held high: the next instruction is latched at the T0 edge immediately after the DONE cycle. Back-to-back instructions have a 1-cycle T0 gap.
- Inactive defaults outside listed actions: RD_ADDR=0, WR_ADDR=0, ALU_OP=PASS.
- Arithmetic width and overflow are the ALU's concern. The controller only sequences.

Test Plan:
- Reset: assert RESETb=0 mid-ADD at T2 -> TIME=0, all enables 0 immediately without waiting for a clock edge. Release, EXEC=0 -> stays T0.
- LOAD: INSTR=10'b0000_10_00_00, EXEC pulse -> next cycle TIME=1, EXT_OE=1, WR_EN=1, WR_ADDR=2, DONE=1. Following cycle TIME=0, all outputs 0.
- ADD R1,R3: INSTR=10'b0010_01_11_00 ->
  - T1: REG_OE, RD_ADDR=1, A_EN.
  - T2: RD_ADDR=3, G_EN, ALU_OP=00.
  - T3: G_OE, WR_EN, WR_ADDR=1, DONE.
  - Then T0.
- INV R0,R2 then SUB with EXEC held high ->
  - INV: DONE at T2.
  - One T0 cycle.
  - SUB: latched, ALU_OP=01 at its T2, DONE at T3.
- Interference: change INSTR to LOAD and toggle EXEC during an ADD at T1/T2 -> sequence unchanged, IR unchanged. Illegal OP 4'b1111 -> DONE at T1 with no OE/WR_EN.
- Randomised 1000 instructions: at most one OE high per cycle, WR_EN only with DONE, TIME never exceeds 3.

Source files
------------

// File: rtl/controller_if.sv
// Bus-side signal bundle between the datapath controller and its surroundings:
// instruction/start inputs plus bus-driver, register-file, ALU and display strobes.
interface controller_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 2
);
  logic [DATA_W-1:0] INSTR;
  logic              EXEC;
  logic [1:0]        TIME;
  logic              DONE;
  logic              EXT_OE;
  logic              REG_OE;
  logic              G_OE;
  logic [ADDR_W-1:0] RD_ADDR;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic              A_EN;
  logic              G_EN;
  logic [1:0]        ALU_OP;

  modport master (
    output INSTR, EXEC,
    input  TIME, DONE, EXT_OE, REG_OE, G_OE, RD_ADDR, WR_EN, WR_ADDR, A_EN, G_EN, ALU_OP
  );

  modport slave (
    input  INSTR, EXEC,
    output TIME, DONE, EXT_OE, REG_OE, G_OE, RD_ADDR, WR_EN, WR_ADDR, A_EN, G_EN, ALU_OP
  );
endinterface

// File: rtl/controller.sv
// Timestep sequencer for the 10-bit shared-bus datapath: latches an instruction on EXEC
// and walks T0..T3, decoding every strobe from the current timestep and the held IR.
module controller #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 2
) (
  input  logic        CLK,
  input  logic        RESETb,
  controller_if.slave bus
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_e;
  typedef enum logic [3:0] {
    OP_LOAD = 4'b0000,
    OP_COPY = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_INV  = 4'b0100
  } op_e;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_INV = 2'b10, ALU_PASS = 2'b11} alu_e;

  tstep_e            ts, ts_nxt;
  logic [DATA_W-1:0] ir;
  logic [3:0]        op;
  logic [1:0]        rx, ry;
  logic              done;
  logic              ir_unused;

  assign op        = ir[9:6];
  assign rx        = ir[5:4];
  assign ry        = ir[3:2];
  assign ir_unused = ^ir[1:0];

  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      ts <= T0;
      ir <= '0;
    end else begin
      ts <= ts_nxt;
      if (ts == T0 && bus.EXEC) ir <= bus.INSTR;
    end
  end

  always_comb begin
    ts_nxt = ts;
    if (ts == T0) begin
      if (bus.EXEC) ts_nxt = T1;
    end else if (done) begin
      ts_nxt = T0;
    end else begin
      ts_nxt = tstep_e'(ts + 2'd1);
    end
  end

  // Outputs depend on (ts, ir) only, so INSTR/EXEC never glitch the strobes.
  always_comb begin
    done        = 1'b0;
    bus.EXT_OE  = 1'b0;
    bus.REG_OE  = 1'b0;
    bus.G_OE    = 1'b0;
    bus.RD_ADDR = '0;
    bus.WR_EN   = 1'b0;
    bus.WR_ADDR = '0;
    bus.A_EN    = 1'b0;
    bus.G_EN    = 1'b0;
    bus.ALU_OP  = ALU_PASS;
    unique case (ts)
      T0: ;
      T1: begin
        case (op)
          OP_LOAD: begin
            bus.EXT_OE = 1'b1; bus.WR_EN = 1'b1; bus.WR_ADDR = rx; done = 1'b1;
          end
          OP_COPY: begin
            bus.REG_OE = 1'b1; bus.RD_ADDR = ry;
            bus.WR_EN = 1'b1; bus.WR_ADDR = rx; done = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus.REG_OE = 1'b1; bus.RD_ADDR = rx; bus.A_EN = 1'b1;
          end
          OP_INV: begin
            bus.REG_OE = 1'b1; bus.RD_ADDR = ry; bus.G_EN = 1'b1; bus.ALU_OP = ALU_INV;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        case (op)
          OP_ADD, OP_SUB: begin
            bus.REG_OE = 1'b1; bus.RD_ADDR = ry; bus.G_EN = 1'b1;
            bus.ALU_OP = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
          end
          OP_INV: begin
            bus.G_OE = 1'b1; bus.WR_EN = 1'b1; bus.WR_ADDR = rx; done = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        if (op == OP_ADD || op == OP_SUB) begin
          bus.G_OE = 1'b1; bus.WR_EN = 1'b1; bus.WR_ADDR = rx; done = 1'b1;
        end
      end
    endcase
  end

  assign bus.TIME = ts;
  assign bus.DONE = done;

  a_bus_exclusive: assert property (@(posedge CLK) disable iff (!RESETb)
    $onehot0({bus.EXT_OE, bus.REG_OE, bus.G_OE}));

endmodule
